// File: rtl/uart_tx_fifo_drain.sv
// UART-style serialiser that drains a FIFO: start bit, M data bits LSB first, stop bit.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_drain #(
    parameter int M            = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         empty,
    input  logic [M-1:0] rd,
    output logic         re,
    output logic         tx,
    output logic         busy,
    output logic         frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(M - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [M-1:0] w);
        even_parity = ^w;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd5
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [M-1:0]  sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          baud_last_s;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    // The FIFO is popped only from IDLE, so a frame in flight can never over-read it.
    assign re          = (state_q == S_IDLE) && !empty && !reset;
    assign baud_last_s = (baud_q == BAUD_LAST);

    // Next-state, counter and shift-register logic; outputs derive from the next state
    // so the registered tx/busy/frame_done line up with the state they describe.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                sh_d    = rd;
`ifdef UART_TX_PARITY_EN
                par_d   = even_parity(rd);
`endif
                baud_d  = {CW{1'b0}};
                bit_d   = {BW{1'b0}};
                state_d = S_START;
            end
            S_START: begin
                if (baud_last_s) begin
                    baud_d  = {CW{1'b0}};
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_last_s) begin
                    baud_d = {CW{1'b0}};
                    sh_d   = sh_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = {BW{1'b0}};
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last_s) begin
                    baud_d  = {CW{1'b0}};
                    state_d = S_STOP;
                end else begin
                    baud_d  = baud_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_last_s) begin
                    baud_d  = {CW{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    baud_d  = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = {CW{1'b0}};
                bit_d   = {BW{1'b0}};
            end
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
    end

    // State and output registers with synchronous reset; a reset drops the word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            baud_q       <= {CW{1'b0}};
            bit_q        <= {BW{1'b0}};
            sh_q         <= {M{1'b0}};
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            sh_q         <= sh_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef UART_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench for uart_tx_fifo_drain: a FIFO model feeds the DUT and a line
// monitor decodes every frame and compares it with the queued expected words.
module tb_uart_tx_fifo_drain;

    localparam int M = 4;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME = (M + 2 + PB) * C;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         empty = 1'b1;
    logic [M-1:0] rd = '0;
    logic         re;
    logic         tx;
    logic         busy;
    logic         frame_done;

    uart_tx_fifo_drain #(.M(M), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .empty(empty), .rd(rd),
        .re(re), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int           chk = 0;
    int           err = 0;
    int           cyc = 0;
    int           re_cnt = 0;
    logic         re_n = 1'b0;
    logic [M-1:0] fifo_q[$];
    logic [M-1:0] exp_q[$];
    int           start_q[$];
    logic         wave_q[$];
    bit           mon_active = 1'b0;
    int           mon_cnt = 0;
    logic [15:0]  bits_v = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk++;
        if (act !== expv) begin
            err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // FIFO model: pops on the edge that samples re, data visible just after that edge.
    always @(posedge clk) begin
        #1;
        if (re_n && fifo_q.size() > 0) rd = fifo_q.pop_front();
        empty = (fifo_q.size() == 0);
    end

    // Line monitor: decodes frames mid-bit and checks them against the scoreboard.
    always @(negedge clk) begin
        logic [M-1:0] w;
        re_n = re;
        if (re) begin
            re_cnt++;
            check("re_while_empty", 32'(empty), 32'(0));
        end
        if (reset) begin
            if (mon_active && exp_q.size() > 0) w = exp_q.pop_front();
            mon_active = 1'b0;
        end else begin
            if (!mon_active) begin
                if (tx == 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    bits_v     = '0;
                    start_q.push_back(cyc);
                    wave_q.delete();
                end else begin
                    check("frame_done_idle", 32'(frame_done), 32'(0));
                end
            end
            if (mon_active) begin
                wave_q.push_back(tx);
                check("busy_in_frame", 32'(busy), 32'(1));
                check("frame_done_pos", 32'(frame_done), 32'(mon_cnt == FRAME - 1));
                if (mon_cnt % C == C / 2) bits_v[mon_cnt / C] = tx;
                if (mon_cnt == FRAME - 1) begin
                    mon_active = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(1), 32'(0));
                    end else begin
                        w = exp_q.pop_front();
                        check("start_bit", 32'(bits_v[0]), 32'(0));
                        check("frame_data", 32'(bits_v[M:1]), 32'(w));
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", 32'(bits_v[M+1]), 32'(^w));
`endif
                        check("stop_bit", 32'(bits_v[M+1+PB]), 32'(1));
                    end
                end else begin
                    mon_cnt++;
                end
            end
        end
    end

    task automatic push(input logic [M-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active || fifo_q.size() != 0) && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(n >= maxc), 32'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_wave();
        logic [31:0] v = '0;
        foreach (wave_q[i]) v[i] = wave_q[i];
        return v;
    endfunction

    initial begin
        int base;
        int idx;
        int n;
        logic [31:0] want_a;
        // Reset held three cycles with the FIFO empty.
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 32'(1));
            check("rst_re", 32'(re), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_tx", 32'(tx), 32'(1));
            check("post_rst_re", 32'(re), 32'(0));
            check("post_rst_busy", 32'(busy), 32'(0));
        end
        @(posedge clk); #1;

        // Single word 4'hA, exact waveform.
        base = re_cnt;
        push(4'hA);
        wait_idle(200, "t2_timeout");
        check("t2_re_pulses", 32'(re_cnt - base), 32'(1));
        check("t2_len", 32'(wave_q.size()), 32'(FRAME));
`ifdef UART_TX_PARITY_EN
        want_a = 32'h0F0F_0F00;
`else
        want_a = 32'h00FF_0F00;
`endif
        check("t2_wave", pack_wave(), want_a);

        // Back-to-back 4'h1 and 4'hF.
        base = re_cnt;
        idx  = start_q.size();
        push(4'h1);
        push(4'hF);
        wait_idle(400, "t3_timeout");
        check("t3_re_pulses", 32'(re_cnt - base), 32'(2));
        check("t3_frames", 32'(start_q.size() - idx), 32'(2));
        if (start_q.size() - idx == 2)
            check("t3_gap", 32'(start_q[idx+1] - start_q[idx] - FRAME), 32'(2));
        check("t3_empty", 32'(empty), 32'(1));

        // Reset on the 10th cycle of a 4'h5 frame.
        push(4'h5);
        n = 0;
        while (!(mon_active && mon_cnt == 9) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_timeout", 32'(n >= 200), 32'(0));
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_tx", 32'(tx), 32'(1));
        check("t4_busy", 32'(busy), 32'(0));
        check("t4_re", 32'(re), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        base = re_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("t4_no_re", 32'(re_cnt - base), 32'(0));
        check("t4_dropped", 32'(exp_q.size()), 32'(0));
        check("t4_idle_tx", 32'(tx), 32'(1));

`ifdef UART_TX_PARITY_EN
        // Parity frame for 4'h7.
        push(4'h7);
        wait_idle(200, "t5_timeout");
        check("t5_len", 32'(wave_q.size()), 32'(28));
        check("t5_wave", pack_wave(), 32'h0FF0_FFF0);
`endif

        // Sixteen random words queued at once.
        base = re_cnt;
        for (int i = 0; i < 16; i++) push(M'($urandom_range(0, 15)));
        wait_idle(16 * (FRAME + 2) + 100, "t6_timeout");
        check("t6_re_pulses", 32'(re_cnt - base), 32'(16));
        check("t6_empty", 32'(empty), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
